// File: rtl/neuron_core_pkg.sv
// neuron_core_pkg: shared FSM states, Q16.16 constants and saturating add/subtract helpers.
package neuron_core_pkg;

    typedef enum logic [1:0] {IDLE, COMPUTE, INTEGRATE, FIRE} state_t;

    localparam int FRAC_BITS = 16;
    localparam logic signed [31:0] K_004   = 32'sh00000A3D;
    localparam logic signed [31:0] K_5     = 32'sh00050000;
    localparam logic signed [31:0] K_140   = 32'sh008C0000;
    localparam logic signed [31:0] SAT_MAX = 32'sh7FFFFFFF;
    localparam logic signed [31:0] SAT_MIN = 32'sh80000000;

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] x, input logic signed [31:0] y);
        logic [32:0] s;
        s = {x[31], x} + {y[31], y};
        return (s[32] != s[31]) ? (s[32] ? SAT_MIN : SAT_MAX) : s[31:0];
    endfunction

    function automatic logic signed [31:0] sat_sub(input logic signed [31:0] x, input logic signed [31:0] y);
        logic [32:0] s;
        s = {x[31], x} - {y[31], y};
        return (s[32] != s[31]) ? (s[32] ? SAT_MIN : SAT_MAX) : s[31:0];
    endfunction

endpackage

// File: rtl/neuron_core_mul.sv
// fxp_mul_sat: Q16.16 signed multiply, truncating to bits [47:16] with saturation on overflow.
module fxp_mul_sat
    import neuron_core_pkg::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] p
);
    logic signed [63:0] full;
    always_comb begin
        full = 64'(a) * 64'(b);
        p = (&full[63:47] | ~|full[63:47]) ? full[47:16] : (full[63] ? SAT_MIN : SAT_MAX);
    end
endmodule

// File: rtl/neuron_core.sv
// neuron_core: Izhikevich / LIF neuron, one Euler step per start_update over a 4-state pipeline.
module neuron_core
    import neuron_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] param_a,
    input  logic [31:0] param_b,
    input  logic [31:0] param_c,
    input  logic [31:0] param_d,
    input  logic [31:0] param_vth,
    input  logic [31:0] current_input,
    input  logic        mode,
    input  logic        start_update,
    input  logic        start_reset,
    output logic        busy,
    output logic        spike_detected,
    output logic [31:0] v_out,
    output logic [31:0] u_out
);
    state_t state, state_n;
    logic signed [31:0] v, u, a_l, b_l, c_l, d_l, vth_l, i_l;
    logic               mode_l;
    logic signed [31:0] vv_r, fv_r, bv_r, vn_r, un_r;
    logic signed [31:0] vv, fv, bv, kvv, ad, bc, diff, vn, un;

    fxp_mul_sat u_vv  (.a(v),       .b(v),       .p(vv));
    fxp_mul_sat u_fv  (.a(K_5),     .b(v),       .p(fv));
    fxp_mul_sat u_bv  (.a(b_l),     .b(v),       .p(bv));
    fxp_mul_sat u_kvv (.a(K_004),   .b(vv_r),    .p(kvv));
    fxp_mul_sat u_ad  (.a(a_l),     .b(diff),    .p(ad));
    fxp_mul_sat u_bc  (.a(param_b), .b(param_c), .p(bc));

    // Every add/sub saturates in left-to-right order of the update equations.
    always_comb begin
        diff = mode_l ? sat_sub(v, c_l) : sat_sub(bv_r, u);
        vn = mode_l ? sat_sub(sat_add(v, i_l), ad)
                    : sat_add(sat_sub(sat_add(sat_add(sat_add(v, kvv), fv_r), K_140), u), i_l);
        un = mode_l ? u : sat_add(u, ad);
    end

    always_comb begin
        state_n = state;
        if (start_reset)
            state_n = IDLE;
        else
            case (state)
                IDLE:      state_n = start_update ? COMPUTE : IDLE;
                COMPUTE:   state_n = INTEGRATE;
                INTEGRATE: state_n = FIRE;
                default:   state_n = IDLE;
            endcase
        busy = state != IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0; u <= '0; spike_detected <= 1'b0;
            a_l <= '0; b_l <= '0; c_l <= '0; d_l <= '0; vth_l <= '0; i_l <= '0; mode_l <= 1'b0;
            vv_r <= '0; fv_r <= '0; bv_r <= '0; vn_r <= '0; un_r <= '0;
        end else if (start_reset) begin
            v <= param_c;
            u <= mode ? '0 : bc;
            spike_detected <= 1'b0;
        end else
            case (state)
                IDLE: if (start_update) begin
                    a_l <= param_a; b_l <= param_b; c_l <= param_c; d_l <= param_d;
                    vth_l <= param_vth; i_l <= current_input; mode_l <= mode;
                    spike_detected <= 1'b0;
                end
                COMPUTE: begin
                    vv_r <= vv; fv_r <= fv; bv_r <= bv;
                end
                INTEGRATE: begin
                    vn_r <= vn; un_r <= un;
                end
                default: if (vn_r >= vth_l) begin
                    v <= c_l;
                    u <= mode_l ? un_r : sat_add(un_r, d_l);
                    spike_detected <= 1'b1;
                end else begin
                    v <= vn_r;
                    u <= un_r;
                end
            endcase
    end

    assign v_out = v;
    assign u_out = u;
endmodule

// File: tb/tb_neuron_core.sv
// tb_neuron_core: directed checks of reset, both neuron modes, firing, abort and saturation.
module tb_neuron_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] param_a = '0, param_b = '0, param_c = '0, param_d = '0, param_vth = '0, current_input = '0;
    logic        mode = 1'b0, start_update = 1'b0, start_reset = 1'b0;
    logic        busy, spike_detected;
    logic [31:0] v_out, u_out;
    int total = 0;
    int bad = 0;

    neuron_core dut (
        .clk(clk), .rst(rst), .param_a(param_a), .param_b(param_b), .param_c(param_c),
        .param_d(param_d), .param_vth(param_vth), .current_input(current_input), .mode(mode),
        .start_update(start_update), .start_reset(start_reset), .busy(busy),
        .spike_detected(spike_detected), .v_out(v_out), .u_out(u_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_update();
        start_update = 1'b1;
        step();
        start_update = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_v", v_out, 32'h0);
        chk("rst_u", u_out, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_spike", {31'b0, spike_detected}, 32'h0);

        current_input = 32'h000A0000;
        param_vth = 32'h7FFFFFFF;
        start_update = 1'b1;
        step();
        start_update = 1'b0;
        current_input = 32'h0;
        chk("b1_busy", {31'b0, busy}, 32'h1);
        chk("b1_v_hold", v_out, 32'h0);
        step();
        chk("b2_busy", {31'b0, busy}, 32'h1);
        step();
        chk("b3_busy", {31'b0, busy}, 32'h1);
        step();
        chk("b4_idle", {31'b0, busy}, 32'h0);
        chk("izh_v", v_out, 32'h00960000);
        chk("izh_u", u_out, 32'h0);
        chk("izh_spike", {31'b0, spike_detected}, 32'h0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        current_input = 32'h000A0000;
        param_vth = 32'h001E0000;
        param_d = 32'h00080000;
        run_update();
        chk("fire_v", v_out, 32'h0);
        chk("fire_u", u_out, 32'h00080000);
        chk("fire_spike", {31'b0, spike_detected}, 32'h1);
        start_update = 1'b1;
        step();
        start_update = 1'b0;
        chk("accept_clears_spike", {31'b0, spike_detected}, 32'h0);
        step();
        step();
        step();
        chk("fire2_u", u_out, 32'h00100000);
        chk("fire2_spike", {31'b0, spike_detected}, 32'h1);

        param_a = 32'h0000051F;
        param_b = 32'h00003333;
        param_c = 32'hFFBF0000;
        param_d = 32'h0;
        param_vth = 32'h7FFFFFFF;
        current_input = 32'h0;
        start_reset = 1'b1;
        step();
        start_reset = 1'b0;
        chk("sreset_v", v_out, 32'hFFBF0000);
        chk("sreset_u", u_out, 32'hFFF3000D);
        chk("sreset_busy", {31'b0, busy}, 32'h0);
        chk("sreset_spike", {31'b0, spike_detected}, 32'h0);

        param_c = 32'h00140000;
        start_update = 1'b1;
        step();
        start_update = 1'b0;
        step();
        chk("abort_pre_busy", {31'b0, busy}, 32'h1);
        param_c = 32'hFFBF0000;
        start_reset = 1'b1;
        step();
        start_reset = 1'b0;
        chk("abort_v", v_out, 32'hFFBF0000);
        chk("abort_u", u_out, 32'hFFF3000D);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        step();
        chk("abort_stays_idle", {31'b0, busy}, 32'h0);
        chk("abort_v_hold", v_out, 32'hFFBF0000);

        param_c = 32'h00050000;
        mode = 1'b1;
        start_reset = 1'b1;
        start_update = 1'b1;
        step();
        start_reset = 1'b0;
        start_update = 1'b0;
        chk("both_v", v_out, 32'h00050000);
        chk("both_u", u_out, 32'h0);
        chk("both_busy", {31'b0, busy}, 32'h0);
        step();
        chk("both_dropped", {31'b0, busy}, 32'h0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        param_a = 32'h00008000;
        param_b = 32'h0;
        param_c = 32'h0;
        current_input = 32'h00010000;
        run_update();
        chk("lif1_v", v_out, 32'h00010000);
        chk("lif1_u", u_out, 32'h0);
        start_update = 1'b1;
        step();
        step();
        start_update = 1'b0;
        step();
        step();
        chk("lif2_v", v_out, 32'h00018000);
        chk("lif2_busy", {31'b0, busy}, 32'h0);
        step();
        chk("busy_start_ignored", {31'b0, busy}, 32'h0);
        chk("lif2_v_hold", v_out, 32'h00018000);

        param_c = 32'h7F000000;
        start_reset = 1'b1;
        step();
        start_reset = 1'b0;
        chk("sat_pre_v", v_out, 32'h7F000000);
        param_c = 32'h7E000000;
        param_a = 32'h00010000;
        current_input = 32'h7F000000;
        run_update();
        chk("sat_v", v_out, 32'h7EFFFFFF);
        chk("sat_spike", {31'b0, spike_detected}, 32'h0);

        mode = 1'b0;
        param_b = 32'h0;
        param_c = 32'h000A0000;
        start_reset = 1'b1;
        step();
        start_reset = 1'b0;
        chk("izh10_pre_u", u_out, 32'h0);
        param_a = 32'h00010000;
        param_b = 32'h00010000;
        current_input = 32'h0;
        run_update();
        chk("izh10_v", v_out, 32'h00CBFFD4);
        chk("izh10_u", u_out, 32'h000A0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/neuron_core.md
NEURON_CORE -- requirements
Module: neuron_core

Interface
REQ-001 The block SHALL have no parameters; all data is signed Q16.16 fixed point, 32 bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 param_a  input  32  Izhikevich a (mode 0) / leak rate (mode 1).
REQ-005 param_b  input  32  Izhikevich b (mode 0), unused in mode 1.
REQ-006 param_c, param_d  input  32 each  reset potential c; recovery increment d (mode 0 only).
REQ-007 param_vth  input  32  firing threshold.
REQ-008 current_input  input  32  input current I.
REQ-009 mode  input  1  0 = Izhikevich, 1 = leaky integrate-and-fire (LIF).
REQ-010 start_update  input  1  single-cycle pulse requesting one integration step.
REQ-011 start_reset  input  1  single-cycle pulse requesting state re-initialisation.
REQ-012 busy  output  1  high while an update is in progress.
REQ-013 spike_detected  output  1  sticky flag: a spike occurred in the most recent update.
REQ-014 v_out, u_out  output  32 each  membrane potential v and recovery variable u.

Function
REQ-015 FSM states SHALL be IDLE, COMPUTE, INTEGRATE, FIRE; busy = 1 in every state except IDLE.
REQ-016 start_update sampled high in IDLE at edge k SHALL move to COMPUTE; results and busy = 0 SHALL be visible after edge k+3 (IDLE -> COMPUTE -> INTEGRATE -> FIRE -> IDLE).
REQ-017 Accepting start_update SHALL clear spike_detected at edge k; start_update outside IDLE SHALL be ignored.
REQ-018 Inputs SHALL be latched at edge k; later changes do not affect that update.
REQ-019 Mode 0 (Euler, dt = 1, old v,u): v' = v + 0.04*v*v + 5*v + 140 - u + I; u' = u + a*(b*v - u).
REQ-020 Mode 1: v' = v + I - a*(v - c); u' = u.
REQ-021 FIRE: if v' >= vth (signed): v = c, u = u' + d (mode 0) or u' (mode 1), spike_detected = 1; else v = v', u = u'.
REQ-022 Constants SHALL be 0.04 = 0x00000A3D, 5 = 0x00050000, 140 = 0x008C0000.
REQ-023 Multiply SHALL form the full signed 64-bit product and take bits [47:16], truncating; overflow of that slice saturates.
REQ-024 Every add/subtract SHALL saturate to 0x7FFFFFFF / 0x80000000, never wrap.
REQ-025 start_reset SHALL be honoured in any state, aborting any update in progress, with a 1-cycle effect: v = c, u = b*c (mode 0) or 0 (mode 1), spike_detected = 0, state = IDLE, busy = 0.
REQ-026 start_reset and start_update high together: reset SHALL win and the update is dropped.
REQ-027 v_out/u_out SHALL change only at the FIRE->IDLE edge, on start_reset, or on rst.

Reset
REQ-028 rst SHALL force state = IDLE, v = 0, u = 0, busy = 0, spike_detected = 0, and clear the latched inputs.

Structure
REQ-029 Package neuron_core_pkg SHALL hold the FSM state enum, FRAC_BITS = 16, and constants K_004, K_5, K_140, SAT_MAX, SAT_MIN.
REQ-030 Sub-module fxp_mul_sat (Q16.16 signed multiply with saturation, REQ-023) SHALL be used for every product.

Verification
REQ-031 rst; all params 0, I = 0x000A0000, vth = 0x7FFFFFFF, mode 0, one update -> busy high for 3 cycles, v_out = 0x00960000, u_out = 0, spike_detected = 0.
REQ-032 Same as REQ-031 but vth = 0x001E0000, d = 0x00080000 -> v_out = 0 (c), u_out = 0x00080000, spike_detected = 1; next accepted update clears it at acceptance.
REQ-033 a = 0x0000051F, b = 0x00003333, c = 0xFFBF0000, mode 0, start_reset -> v_out = 0xFFBF0000, u_out = 0xFFF3000D after 1 cycle, busy = 0.
REQ-034 mode 1, a = 0x00008000, c = 0, I = 0x00010000, vth = 0x7FFFFFFF, from v = 0, two updates -> v_out = 0x00010000 then 0x00018000, u_out = 0.
REQ-035 start_update during busy is ignored; start_reset in INTEGRATE aborts -> REQ-025 values; start_reset with start_update -> reset only.
REQ-036 v = 0x7F000000 with I = 0x7F000000 -> v' saturates to 0x7FFFFFFF, no wrap.
